// File: rtl/if_fetch_ctrl_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, sticky error codes and the PC step.
package if_fetch_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } fetch_state_t;

   typedef enum logic [1:0] {
      ERR_NONE     = 2'b00,
      ERR_MISALIGN = 2'b01,
      ERR_RANGE    = 2'b10
   } fetch_err_t;

   localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// Fetch-stage bundle: hazard/redirect controls, instruction-memory port and IF/ID outputs.
interface if_fetch_ctrl_if;
   logic        stall_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        halt_i;
   logic [31:0] imem_addr_o;
   logic [31:0] imem_data_i;
   logic        ifid_valid_o;
   logic [31:0] ifid_pc_o;
   logic [31:0] ifid_instr_o;
   logic        halted_o;
   logic [1:0]  err_o;
   logic [31:0] fetch_cnt_o;

   modport master (
      input  stall_i, redirect_i, redirect_pc_i, halt_i, imem_data_i,
      output imem_addr_o, ifid_valid_o, ifid_pc_o, ifid_instr_o, halted_o, err_o, fetch_cnt_o
   );

   modport slave (
      output stall_i, redirect_i, redirect_pc_i, halt_i, imem_data_i,
      input  imem_addr_o, ifid_valid_o, ifid_pc_o, ifid_instr_o, halted_o, err_o, fetch_cnt_o
   );
endinterface

// File: rtl/if_fetch_ctrl_ifid_reg.sv
// IF/ID pipeline register: load captures pc/instr, squash drops valid only, otherwise hold.
module ifid_reg (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        squash,
   input  logic [31:0] pc_d,
   input  logic [31:0] instr_d,
   output logic        valid,
   output logic [31:0] pc,
   output logic [31:0] instr
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= 1'b0;
         pc    <= 32'd0;
         instr <= 32'd0;
      end else if (load) begin
         valid <= 1'b1;
         pc    <= pc_d;
         instr <= instr_d;
      end else if (squash) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/if_fetch_ctrl.sv
// Fetch-stage controller: owns the PC, sequences boot/run/halt and feeds the IF/ID register.
//   state   | meaning
//   ST_BOOT | waiting BOOT_CYCLES edges for memory to settle, inputs ignored
//   ST_RUN  | fetching; priority halt > redirect > stall > range check > fetch
//   ST_HALT | terminal until reset, IF/ID invalid, err_o sticky
module if_fetch_ctrl
   import if_fetch_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          BOOT_CYCLES = 2,
   parameter int          MEM_BYTES   = 256
) (
   input  logic            clk,
   input  logic            rst,
   if_fetch_ctrl_if.master bus
);

   localparam logic [3:0]  BOOT_LAST = 4'(BOOT_CYCLES - 1);
   localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

   fetch_state_t state;
   fetch_err_t   err;
   logic [3:0]   boot_cnt;
   logic [31:0]  pc;
   logic [31:0]  fetch_cnt;
   logic         halted;
   logic         load;
   logic         squash;
   logic         pc_oor;
   logic         redirect_misaligned;

   assign pc_oor              = (pc >= MEM_LIMIT);
   assign redirect_misaligned = (bus.redirect_pc_i[1:0] != 2'b00);

   // IF/ID control mirrors the RUN priority chain used for the PC below.
   always_comb begin
      load   = 1'b0;
      squash = 1'b0;
      if (state == ST_RUN) begin
         if (bus.halt_i || bus.redirect_i) begin
            squash = 1'b1;
         end else if (!bus.stall_i) begin
            if (pc_oor) squash = 1'b1;
            else        load   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_BOOT;
         boot_cnt  <= 4'd0;
         pc        <= RESET_PC;
         err       <= ERR_NONE;
         halted    <= 1'b0;
         fetch_cnt <= 32'd0;
      end else begin
         case (state)
            ST_BOOT: begin
               boot_cnt <= boot_cnt + 4'd1;
               if (boot_cnt == BOOT_LAST) state <= ST_RUN;
            end
            ST_RUN: begin
               if (bus.halt_i) begin
                  state  <= ST_HALT;
                  halted <= 1'b1;
               end else if (bus.redirect_i) begin
                  if (redirect_misaligned) begin
                     err    <= ERR_MISALIGN;
                     state  <= ST_HALT;
                     halted <= 1'b1;
                  end else begin
                     pc <= bus.redirect_pc_i;
                  end
               end else if (!bus.stall_i) begin
                  if (pc_oor) begin
                     err    <= ERR_RANGE;
                     state  <= ST_HALT;
                     halted <= 1'b1;
                  end else begin
                     pc        <= pc + PC_INC;
                     fetch_cnt <= fetch_cnt + 32'd1;
                  end
               end
            end
            ST_HALT: begin
               halted <= 1'b1;
            end
            default: begin
               state  <= ST_HALT;
               halted <= 1'b1;
            end
         endcase
      end
   end

   ifid_reg u_ifid_reg (
      .clk     (clk),
      .rst     (rst),
      .load    (load),
      .squash  (squash),
      .pc_d    (pc),
      .instr_d (bus.imem_data_i),
      .valid   (bus.ifid_valid_o),
      .pc      (bus.ifid_pc_o),
      .instr   (bus.ifid_instr_o)
   );

   assign bus.imem_addr_o = pc;
   assign bus.halted_o    = halted;
   assign bus.err_o       = err;
   assign bus.fetch_cnt_o = fetch_cnt;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: vector table with a fetch scoreboard, plus an out-of-range run on a 16-byte memory.
module tb_if_fetch_ctrl;

   localparam logic [31:0] MASK = 32'hA5A5_0000;

   typedef struct {
      bit          rp;
      bit          st;
      bit          rd;
      logic [31:0] rpc;
      bit          hl;
      bit          ev;
      logic [31:0] epc;
      logic [31:0] eaddr;
      logic [31:0] ecnt;
      bit          eh;
      logic [1:0]  eerr;
      bit          ld;
   } vec_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } sb_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   vec_t tv[24];
   sb_t  sbq[$];
   logic [31:0] prev_cnt;

   always #5 clk = ~clk;

   if_fetch_ctrl_if bif ();
   if_fetch_ctrl_if bif2 ();

   assign bif.imem_data_i  = bif.imem_addr_o ^ MASK;
   assign bif2.imem_data_i = bif2.imem_addr_o ^ MASK;

   if_fetch_ctrl #(.RESET_PC(32'h0), .BOOT_CYCLES(2), .MEM_BYTES(256)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   if_fetch_ctrl #(.RESET_PC(32'h0), .BOOT_CYCLES(2), .MEM_BYTES(16)) dut_oor (
      .clk (clk),
      .rst (rst),
      .bus (bif2)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(bit rp, bit st, bit rd, logic [31:0] rpc, bit hl, bit ev,
                               logic [31:0] epc, logic [31:0] eaddr, logic [31:0] ecnt,
                               bit eh, logic [1:0] eerr, bit ld);
      vec_t v;
      v.rp = rp; v.st = st; v.rd = rd; v.rpc = rpc; v.hl = hl; v.ev = ev;
      v.epc = epc; v.eaddr = eaddr; v.ecnt = ecnt; v.eh = eh; v.eerr = eerr; v.ld = ld;
      return v;
   endfunction

   task automatic chk_reset(input string tag);
      chk({tag, " valid"}, 32'(bif.ifid_valid_o), 32'd0);
      chk({tag, " ifid_pc"}, bif.ifid_pc_o, 32'd0);
      chk({tag, " ifid_instr"}, bif.ifid_instr_o, 32'd0);
      chk({tag, " addr"}, bif.imem_addr_o, 32'd0);
      chk({tag, " halted"}, 32'(bif.halted_o), 32'd0);
      chk({tag, " err"}, 32'(bif.err_o), 32'd0);
      chk({tag, " cnt"}, bif.fetch_cnt_o, 32'd0);
   endtask

   task automatic drive_idle();
      bif.stall_i = 1'b0; bif.redirect_i = 1'b0; bif.redirect_pc_i = 32'd0; bif.halt_i = 1'b0;
   endtask

   // Async pulse mid-cycle, checked before any clock edge, released just after a rising edge.
   task automatic do_reset(input string tag);
      @(negedge clk);
      drive_idle();
      #2 rst = 1'b1;
      #1 chk_reset(tag);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      prev_cnt = 32'd0;
      sbq.delete();
   endtask

   initial begin
      logic [31:0] e_instr;
      drive_idle();
      bif2.stall_i = 1'b0; bif2.redirect_i = 1'b0; bif2.redirect_pc_i = 32'd0; bif2.halt_i = 1'b0;
      prev_cnt = 32'd0;

      //         rp st rd rpc        hl ev epc     eaddr   ecnt eh eerr ld
      tv[0]  = mk(0, 0, 0, 32'h0,    0, 0, 32'h0,  32'h0,  0,   0, 2'd0, 0);
      tv[1]  = mk(0, 0, 0, 32'h0,    0, 0, 32'h0,  32'h0,  0,   0, 2'd0, 0);
      tv[2]  = mk(0, 0, 0, 32'h0,    0, 1, 32'h0,  32'h4,  1,   0, 2'd0, 1);
      tv[3]  = mk(0, 0, 0, 32'h0,    0, 1, 32'h4,  32'h8,  2,   0, 2'd0, 1);
      tv[4]  = mk(0, 1, 0, 32'h0,    0, 1, 32'h4,  32'h8,  2,   0, 2'd0, 0);
      tv[5]  = mk(0, 1, 0, 32'h0,    0, 1, 32'h4,  32'h8,  2,   0, 2'd0, 0);
      tv[6]  = mk(0, 1, 0, 32'h0,    0, 1, 32'h4,  32'h8,  2,   0, 2'd0, 0);
      tv[7]  = mk(0, 0, 0, 32'h0,    0, 1, 32'h8,  32'hC,  3,   0, 2'd0, 1);
      tv[8]  = mk(0, 1, 1, 32'h40,   0, 0, 32'h8,  32'h40, 3,   0, 2'd0, 0);
      tv[9]  = mk(0, 0, 0, 32'h0,    0, 1, 32'h40, 32'h44, 4,   0, 2'd0, 1);
      tv[10] = mk(0, 0, 0, 32'h0,    0, 1, 32'h44, 32'h48, 5,   0, 2'd0, 1);
      tv[11] = mk(0, 0, 1, 32'h80,   1, 0, 32'h44, 32'h48, 5,   1, 2'd0, 0);
      tv[12] = mk(0, 1, 1, 32'h100,  0, 0, 32'h44, 32'h48, 5,   1, 2'd0, 0);
      tv[13] = mk(1, 0, 0, 32'h0,    0, 0, 32'h0,  32'h0,  0,   0, 2'd0, 0);
      tv[14] = mk(0, 0, 0, 32'h0,    0, 0, 32'h0,  32'h0,  0,   0, 2'd0, 0);
      tv[15] = mk(0, 0, 0, 32'h0,    0, 1, 32'h0,  32'h4,  1,   0, 2'd0, 1);
      tv[16] = mk(0, 0, 0, 32'h0,    0, 1, 32'h4,  32'h8,  2,   0, 2'd0, 1);
      tv[17] = mk(0, 0, 0, 32'h0,    0, 1, 32'h8,  32'hC,  3,   0, 2'd0, 1);
      tv[18] = mk(0, 0, 0, 32'h0,    0, 1, 32'hC,  32'h10, 4,   0, 2'd0, 1);
      tv[19] = mk(0, 0, 0, 32'h0,    0, 1, 32'h10, 32'h14, 5,   0, 2'd0, 1);
      tv[20] = mk(0, 0, 1, 32'h42,   0, 0, 32'h10, 32'h14, 5,   1, 2'd1, 0);
      tv[21] = mk(0, 1, 1, 32'h40,   0, 0, 32'h10, 32'h14, 5,   1, 2'd1, 0);
      tv[22] = mk(0, 0, 0, 32'h0,    1, 0, 32'h10, 32'h14, 5,   1, 2'd1, 0);
      tv[23] = mk(1, 0, 0, 32'h0,    0, 0, 32'h0,  32'h0,  0,   0, 2'd0, 0);

      repeat (3) @(posedge clk);
      chk_reset("por");
      #1 rst = 1'b0;

      for (int i = 0; i < 24; i++) begin
         if (tv[i].rp) do_reset($sformatf("rst_mid%0d", i));
         @(negedge clk);
         bif.stall_i       = tv[i].st;
         bif.redirect_i    = tv[i].rd;
         bif.redirect_pc_i = tv[i].rpc;
         bif.halt_i        = tv[i].hl;
         if (tv[i].ld) sbq.push_back('{pc: tv[i].epc, instr: tv[i].epc ^ MASK});
         @(posedge clk);
         #1;
         e_instr = (tv[i].ecnt == 32'd0) ? 32'd0 : (tv[i].epc ^ MASK);
         chk($sformatf("s%0d valid", i), 32'(bif.ifid_valid_o), 32'(tv[i].ev));
         chk($sformatf("s%0d ifid_pc", i), bif.ifid_pc_o, tv[i].epc);
         chk($sformatf("s%0d ifid_instr", i), bif.ifid_instr_o, e_instr);
         chk($sformatf("s%0d addr", i), bif.imem_addr_o, tv[i].eaddr);
         chk($sformatf("s%0d cnt", i), bif.fetch_cnt_o, tv[i].ecnt);
         chk($sformatf("s%0d halted", i), 32'(bif.halted_o), 32'(tv[i].eh));
         chk($sformatf("s%0d err", i), 32'(bif.err_o), 32'(tv[i].eerr));
         if (bif.ifid_valid_o && bif.fetch_cnt_o != prev_cnt) begin
            if (sbq.size() == 0) begin
               chk($sformatf("s%0d sb_unexpected", i), bif.ifid_pc_o, 32'hFFFF_FFFF);
            end else begin
               sb_t exp_e;
               exp_e = sbq.pop_front();
               chk($sformatf("s%0d sb_pc", i), bif.ifid_pc_o, exp_e.pc);
               chk($sformatf("s%0d sb_instr", i), bif.ifid_instr_o, exp_e.instr);
            end
         end
         prev_cnt = bif.fetch_cnt_o;
      end
      chk("sb_leftover", 32'(sbq.size()), 32'd0);

      // Out-of-range run on a 16-byte memory: four fetches, then a range halt.
      do_reset("rst_oor");
      for (int e = 1; e <= 8; e++) begin
         logic [31:0] x_pc, x_addr, x_cnt, x_instr;
         logic        x_valid, x_halt;
         logic [1:0]  x_err;
         @(posedge clk);
         #1;
         x_valid = (e >= 3 && e <= 6);
         x_halt  = (e >= 7);
         x_err   = (e >= 7) ? 2'b10 : 2'b00;
         x_cnt   = (e <= 2) ? 32'd0 : (e <= 6) ? 32'(e - 2) : 32'd4;
         x_pc    = (e <= 3) ? 32'd0 : (e <= 6) ? 32'((e - 3) * 4) : 32'd12;
         x_addr  = (e <= 2) ? 32'd0 : (e <= 6) ? 32'((e - 2) * 4) : 32'd16;
         x_instr = (e < 3) ? 32'd0 : (x_pc ^ MASK);
         chk($sformatf("oor e%0d valid", e), 32'(bif2.ifid_valid_o), 32'(x_valid));
         chk($sformatf("oor e%0d halted", e), 32'(bif2.halted_o), 32'(x_halt));
         chk($sformatf("oor e%0d err", e), 32'(bif2.err_o), 32'(x_err));
         chk($sformatf("oor e%0d cnt", e), bif2.fetch_cnt_o, x_cnt);
         chk($sformatf("oor e%0d ifid_pc", e), bif2.ifid_pc_o, x_pc);
         chk($sformatf("oor e%0d ifid_instr", e), bif2.ifid_instr_o, x_instr);
         chk($sformatf("oor e%0d addr", e), bif2.imem_addr_o, x_addr);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/if_fetch_ctrl.md
# if_fetch_ctrl

Fetch-stage controller for the RISC-V pipeline. It owns the program counter and drives the byte address into the instruction memory, whose read is combinational. It registers the returned word into the IF/ID pipeline register. It also sequences post-reset start-up, hazard stalls, branch/jump redirects and error halts.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `BOOT_CYCLES`, default 2: clock edges to wait after reset before the first fetch, while memory contents settle; range 1..15.
- `MEM_BYTES`, default 256: instruction memory size in bytes. Any fetch address ≥ MEM_BYTES is out of range.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `stall_i` input 1: hazard-unit stall; hold PC and IF/ID.
- `redirect_i` input 1: taken branch or jump from EX.
- `redirect_pc_i` input 32: redirect target (byte address).
- `halt_i` input 1: request to stop fetching.
- `imem_addr_o` output 32: byte address to instruction memory; always equals the PC register.
- `imem_data_i` input 32: instruction word at `imem_addr_o`, same cycle.
- `ifid_valid_o` output 1: IF/ID holds a real instruction.
- `ifid_pc_o` output 32: PC of the IF/ID instruction.
- `ifid_instr_o` output 32: IF/ID instruction word.
- `halted_o` output 1: FSM is in HALT.
- `err_o` output 2: sticky error code. 00 = none, 01 = misaligned redirect, 10 = fetch out of range.
- `fetch_cnt_o` output 32: count of instructions written into IF/ID.

## Operation
- FSM states are BOOT, RUN and HALT.
- **Reset (async):**
  - State goes to BOOT and the boot counter is cleared.
  - PC = RESET_PC.
  - ifid_valid_o = 0, ifid_pc_o = 0, ifid_instr_o = 0.
  - halted_o = 0, err_o = 00, fetch_cnt_o = 0.
- **BOOT:**
  - The counter increments each edge. The FSM moves to RUN on the edge where the counter reaches BOOT_CYCLES−1.
  - ifid_valid_o stays 0. Inputs are ignored, including redirect and halt.
- **RUN:** the following priority applies per edge, highest first.
  1. **halt_i:** go to HALT; ifid_valid_o <= 0; PC holds.
  2. **redirect_i:**
     - If redirect_pc_i[1:0] != 0: err_o <= 01 and go to HALT.
     - Otherwise PC <= redirect_pc_i and ifid_valid_o <= 0 (squash the wrong-path instruction).
     - The redirect overrides stall_i.
  3. **stall_i:** PC and all ifid_* hold; fetch_cnt_o holds.
  4. **PC ≥ MEM_BYTES:** err_o <= 10, go to HALT, ifid_valid_o <= 0.
  5. **Normal fetch:**
     - ifid_instr_o <= imem_data_i, ifid_pc_o <= PC, ifid_valid_o <= 1.
     - PC <= PC + 4, wrapping modulo 2^32.
     - fetch_cnt_o increments, wrapping modulo 2^32.
- **HALT:**
  - Terminal until reset; all inputs are ignored.
  - halted_o = 1. PC, ifid_pc_o and ifid_instr_o hold; ifid_valid_o = 0.
  - err_o is sticky.
- A word 32'h0000_0000 is fetched and passed on like any other word; no decoding happens here.

## Timing
- imem_addr_o is a direct register output, with no combinational path from any input.
- **Fetch latency:** the address is presented in cycle n, and the word appears on ifid_instr_o after the edge ending cycle n.
- **Start-up:** the first valid IF/ID comes BOOT_CYCLES+1 edges after reset deasserts.
- **Redirect:**
  - Asserted in cycle n: the target is on imem_addr_o in cycle n+1.
  - The target instruction is valid in IF/ID after edge n+1.
  - Exactly one bubble results.
- **Stall:** held for k cycles gives exactly k cycles of frozen outputs; fetch resumes at the same PC.
- **Simultaneous events:**
  - halt + redirect: halt wins and PC does not change.
  - redirect + stall: the redirect is taken.
  - An out-of-range PC while stalled is not flagged until the stall drops.
- **Reset mid-operation:** all outputs return to reset values immediately, with no dependency on the clock.

## Structure
- The shared pipeline package holds:
  - the FSM state encoding (BOOT = 2'd0, RUN = 2'd1, HALT = 2'd2);
  - the err_o codes;
  - the PC increment constant 4.
- One natural sub-module is `ifid_reg`: the IF/ID register with load, hold and squash controls plus async reset. Stage boundaries elsewhere can reuse it.
- The FSM, PC and counters stay in `if_fetch_ctrl`.

## Test plan
- **Reset and boot:** hold rst 3 cycles, release with BOOT_CYCLES=2 → ifid_valid_o=0 for 2 edges, first valid instruction with ifid_pc_o=0 on the 3rd edge, fetch_cnt_o=1.
- **Sequential fetch:** memory model returns addr^32'hA5A5_0000 → after 5 fetches ifid_pc_o=16, ifid_instr_o=32'hA5A5_0010, fetch_cnt_o=5.
- **Stall:** stall_i high 3 cycles at PC=8 → outputs frozen for 3 cycles, imem_addr_o=8 throughout, next fetch is ifid_pc_o=8.
- **Redirect with simultaneous stall:** redirect_pc_i=32'h40 and stall_i both high at PC=12 → next cycle imem_addr_o=32'h40, ifid_valid_o=0, then ifid_pc_o=32'h40 valid.
- **Misaligned redirect:** redirect_pc_i=32'h42 → err_o=01, halted_o=1, later redirects and stalls ignored, and async rst clears err_o to 00.
- **Out of range:** MEM_BYTES=16, free-run → after the fetch of PC=12 the next edge gives err_o=10, halted_o=1, fetch_cnt_o=4, ifid_valid_o=0.
